e_mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the E stage. It owns the HI/LO registers and the busy counter that models multiplier/divider latency, and executes mfhi/mflo/mthi/mtlo. It also produces the MDU stall request that the hazard unit ORs into the global stall, which freezes PC and F/D and bubbles D/E.

---
 rtl/e_mdu_ctrl_pkg.sv | 31 +++
 rtl/e_mdu_ctrl_arith.sv | 61 ++++++
 rtl/e_mdu_ctrl.sv | 127 ++++++++++++
 tb/tb_e_mdu_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and default latencies.
// Optional feature macro used by e_mdu_ctrl: E_MDU_DIV0_HOLD_EN.
package e_mdu_ctrl_pkg;

  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd8;

  typedef enum logic {
    MDU_ST_IDLE = 1'b0,
    MDU_ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic mdu_is_muldiv(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) || mdu_is_div(op);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_arith.sv
// Combinational product/quotient/remainder datapath for the MDU.
// Divide by zero yields HI=srcA, LO=all ones and raises div0.
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic [63:0] prod;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] b_safe;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign-extend (or zero-extend) to 64 bits so the low 64 product bits are exact.
  always_comb begin
    if (op == MDU_OP_MULT)
      prod = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    else
      prod = {32'd0, srcA} * {32'd0, srcB};
  end

  assign div0   = mdu_is_div(op) && (srcB == 32'd0);
  assign sgn    = (op == MDU_OP_DIV);
  assign a_neg  = sgn & srcA[31];
  assign b_safe = (srcB == 32'd0) ? 32'd1 : srcB;
  assign b_neg  = sgn & b_safe[31];
  assign a_mag  = a_neg ? (32'd0 - srcA) : srcA;
  assign b_mag  = b_neg ? (32'd0 - b_safe) : b_safe;
  assign uq     = a_mag / b_mag;
  assign ur     = a_mag % b_mag;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quot   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem    = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    hi = prod[63:32];
    lo = prod[31:0];
    if (mdu_is_div(op)) begin
      if (div0) begin
        hi = srcA;
        lo = 32'hFFFF_FFFF;
      end else begin
        hi = rem;
        lo = quot;
      end
    end
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO, latency counter, mf*/mt* and MDU stall.
// Define E_MDU_DIV0_HOLD_EN to keep HI/LO unchanged after a divide by zero.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_mduOp,
  input  logic        i_start,
  input  logic [31:0] i_srcA,
  input  logic [31:0] i_srcB,
  input  logic        i_D_isMdu,
  output logic        or_busy,
  output logic [31:0] or_hi,
  output logic [31:0] or_lo,
  output logic [31:0] or_result,
  output logic        o_stall
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      s_hi_q, s_hi_d;
  logic [31:0]      s_lo_q, s_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             div0_q, div0_d;

  logic [31:0]      ar_hi;
  logic [31:0]      ar_lo;
  logic             ar_div0;
  logic             hold_result;

  e_mdu_arith u_arith (
    .op   (i_mduOp),
    .srcA (i_srcA),
    .srcB (i_srcB),
    .hi   (ar_hi),
    .lo   (ar_lo),
    .div0 (ar_div0)
  );

`ifdef E_MDU_DIV0_HOLD_EN
  assign hold_result = div0_q;
`else
  assign hold_result = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= MDU_ST_IDLE;
      cnt_q   <= '0;
      s_hi_q  <= '0;
      s_lo_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_hi_q  <= s_hi_d;
      s_lo_q  <= s_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_hi_d  = s_hi_q;
    s_lo_d  = s_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    case (state_q)
      MDU_ST_IDLE: begin
        if (i_start && mdu_is_muldiv(i_mduOp)) begin
          s_hi_d  = ar_hi;
          s_lo_d  = ar_lo;
          div0_d  = ar_div0;
          cnt_d   = mdu_is_div(i_mduOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = MDU_ST_BUSY;
        end else if (i_mduOp == MDU_OP_MTHI) begin
          hi_d = i_srcA;
        end else if (i_mduOp == MDU_OP_MTLO) begin
          lo_d = i_srcA;
        end
      end
      MDU_ST_BUSY: begin
        // Starts and mt* arriving here are dropped; the hazard unit prevents them.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MDU_ST_IDLE;
          if (!hold_result) begin
            hi_d = s_hi_q;
            lo_d = s_lo_q;
          end
        end
      end
      default: begin
        state_d = MDU_ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign or_busy = (state_q == MDU_ST_BUSY);
  assign or_hi   = hi_q;
  assign or_lo   = lo_q;
  assign o_stall = i_D_isMdu & (i_start | or_busy);

  always_comb begin
    or_result = 32'd0;
    if (i_mduOp == MDU_OP_MFHI)
      or_result = hi_q;
    else if (i_mduOp == MDU_OP_MFLO)
      or_result = lo_q;
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: vector table of mult/div ops plus corner sequences.
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_mdu;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] result;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_mduOp   (op),
    .i_start   (start),
    .i_srcA    (src_a),
    .i_srcB    (src_b),
    .i_D_isMdu (d_is_mdu),
    .or_busy   (busy),
    .or_hi     (hi),
    .or_lo     (lo),
    .or_result (result),
    .o_stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, return number of observed busy cycles (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt);
    op = o; start = 1'b1; src_a = a; src_b = b;
    step();
    op = MDU_OP_NONE; start = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      busy_cnt++;
      step();
    end
  endtask

  initial begin
    int bc;
    int sc;
    vecs[0] = '{"mult -2*3",         MDU_OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{"multu max*max",     MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2] = '{"mult min*min",      MDU_OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[3] = '{"divu 7/2",          MDU_OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         10};
    vecs[4] = '{"div -7/2",          MDU_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[5] = '{"div 7/-2",          MDU_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[6] = '{"div min/-1",        MDU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[7] = '{"divu max/16",       MDU_OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'hF,         32'h0FFF_FFFF, 10};
    vecs[8] = '{"multu 3*4",         MDU_OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        5};

    rst = 1'b1; op = MDU_OP_NONE; start = 1'b0; src_a = '0; src_b = '0; d_is_mdu = 1'b0;
    step(); step();
    rst = 1'b0;
    d_is_mdu = 1'b1;
    #1;
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset hi",     hi,             32'd0);
    check("reset lo",     lo,             32'd0);
    check("reset result", result,         32'd0);
    check("reset stall",  {31'd0, stall}, 32'd0);
    d_is_mdu = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
      check({vecs[i].name, " busy"}, bc, vecs[i].cycles);
      check({vecs[i].name, " hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, " lo"}, lo, vecs[i].exp_lo);
    end

    // Stall: mfhi waiting in D across a div start + busy window.
    d_is_mdu = 1'b1;
    op = MDU_OP_DIV; start = 1'b1; src_a = 32'd100; src_b = 32'd7;
    #1;
    sc = 0;
    while (stall && sc < 40) begin
      sc++;
      step();
      op = MDU_OP_NONE; start = 1'b0;
      #1;
    end
    check("stall cycles", sc, 32'd11);
    d_is_mdu = 1'b0;
    op = MDU_OP_MFLO;
    #1;
    check("mflo quotient", result, 32'd14);
    op = MDU_OP_MFHI;
    #1;
    check("mfhi remainder", result, 32'd2);
    op = MDU_OP_NONE;
    step();

    // mthi then mfhi; mtlo same-cycle mflo sees the old value.
    op = MDU_OP_MTHI; src_a = 32'h1234_5678;
    step();
    op = MDU_OP_MFHI;
    #1;
    check("mthi->mfhi", result, 32'h1234_5678);
    op = MDU_OP_MTLO; src_a = 32'hCAFE_0001;
    step();
    op = MDU_OP_MFLO;
    #1;
    check("mtlo->mflo", result, 32'hCAFE_0001);
    op = MDU_OP_MTHI; src_a = 32'd5;
    step();
    op = MDU_OP_MTLO; src_a = 32'd6;
    step();
    op = MDU_OP_NONE;

    // Start with a non-mult/div op is ignored.
    op = MDU_OP_MFHI; start = 1'b1;
    step();
    start = 1'b0; op = MDU_OP_NONE;
    check("bad start busy", {31'd0, busy}, 32'd0);

    run_op(MDU_OP_DIV, 32'd9, 32'd0, bc);
    check("div0 busy", bc, 32'd10);
`ifdef E_MDU_DIV0_HOLD_EN
    check("div0 hi", hi, 32'd5);
    check("div0 lo", lo, 32'd6);
`else
    check("div0 hi", hi, 32'd9);
    check("div0 lo", lo, 32'hFFFF_FFFF);
`endif

    // Reset mid-multu: busy and HI/LO clear without waiting for a clock edge.
    op = MDU_OP_MULTU; start = 1'b1; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    step();
    op = MDU_OP_NONE; start = 1'b0;
    step(); step();
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset hi", hi, 32'd0);
    check("async reset lo", lo, 32'd0);
    step();
    rst = 1'b0;
    step();
    run_op(MDU_OP_MULTU, 32'd3, 32'd4, bc);
    check("post-reset busy", bc, 32'd5);
    check("post-reset hi", hi, 32'd0);
    check("post-reset lo", lo, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
